// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory stage behind the load-store queue
// One request at a time: a forwarded load completes at once, anything else waits out MEM_LATENCY.
module mem_access_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_pc,
  input  logic [5:0]  req_rob,
  input  logic [5:0]  req_dest,
  input  logic [31:0] req_addr,
  input  logic        req_is_store,
  input  logic        req_byte,
  input  logic [31:0] req_store_data,
  input  logic        req_fwd_valid,
  input  logic [31:0] req_fwd_data,
  output logic        cmp_valid,
  output logic [31:0] cmp_pc,
  output logic [5:0]  cmp_rob,
  output logic [5:0]  cmp_dest,
  output logic [31:0] cmp_data,
  output logic        cmp_is_store,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;

  logic [3:0]    cnt;
  logic [31:0]   last_pc, pc_q, sdata_q, result_q;
  logic [5:0]    rob_q, dest_q;
  logic [AW+1:0] addr_q;
  logic          is_store_q, byte_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic accept, fwd, mem_op;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic        unused_addr;

  // Zero PC is an LSQ bubble; a repeated PC is the same entry held over several cycles.
  assign accept  = (state == IDLE) && req_valid && (req_pc != 32'd0) && (req_pc != last_pc);
  assign fwd     = req_fwd_valid && !req_is_store;
  assign mem_op  = (state == ACCESS) && (cnt == 4'd0);
  assign rd_word = mem[addr_q[AW+1:2]];
  assign rd_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
  assign unused_addr = ^req_addr[31:AW+2];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = fwd ? RESP : ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_pc    <= 32'd0;
      pc_q       <= 32'd0;
      rob_q      <= 6'd0;
      dest_q     <= 6'd0;
      addr_q     <= '0;
      is_store_q <= 1'b0;
      byte_q     <= 1'b0;
      sdata_q    <= 32'd0;
      result_q   <= 32'd0;
    end else begin
      state <= state_nx;
      if (accept) begin
        last_pc    <= req_pc;
        pc_q       <= req_pc;
        rob_q      <= req_rob;
        dest_q     <= req_dest;
        addr_q     <= req_addr[AW+1:0];
        is_store_q <= req_is_store;
        byte_q     <= req_byte;
        sdata_q    <= req_store_data;
        cnt        <= LAT_M1;
        result_q   <= fwd ? req_fwd_data : 32'd0;
      end
      if (state == ACCESS && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (mem_op && !is_store_q)
        result_q <= byte_q ? {{24{rd_byte[7]}}, rd_byte} : rd_word;
    end
  end

  // Memory contents survive reset; an aborted request never reaches mem_op.
  always_ff @(posedge clk) begin
    if (mem_op && is_store_q) begin
      if (byte_q) mem[addr_q[AW+1:2]][{addr_q[1:0], 3'b000} +: 8] <= sdata_q[7:0];
      else        mem[addr_q[AW+1:2]] <= sdata_q;
    end
  end

  assign req_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign cmp_valid    = (state == RESP);
  assign cmp_pc       = cmp_valid ? pc_q : 32'd0;
  assign cmp_rob      = cmp_valid ? rob_q : 6'd0;
  assign cmp_dest     = cmp_valid ? dest_q : 6'd0;
  assign cmp_data     = cmp_valid ? result_q : 32'd0;
  assign cmp_is_store = cmp_valid && is_store_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed bench for mem_access_unit with a byte-level reference model
// The model decides acceptance, latency and data from a byte array; directed literals pin it.
module tb_mem_access_unit;
  localparam int L = 2;

  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_ready, req_is_store = 0, req_byte = 0, req_fwd_valid = 0;
  logic [31:0] req_pc = 0, req_addr = 0, req_store_data = 0, req_fwd_data = 0;
  logic [5:0]  req_rob = 0, req_dest = 0;
  logic        cmp_valid, cmp_is_store, busy;
  logic [31:0] cmp_pc, cmp_data;
  logic [5:0]  cmp_rob, cmp_dest;

  mem_access_unit #(.DEPTH_WORDS(256), .MEM_LATENCY(L)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_pc(req_pc), .req_rob(req_rob), .req_dest(req_dest), .req_addr(req_addr),
    .req_is_store(req_is_store), .req_byte(req_byte), .req_store_data(req_store_data),
    .req_fwd_valid(req_fwd_valid), .req_fwd_data(req_fwd_data),
    .cmp_valid(cmp_valid), .cmp_pc(cmp_pc), .cmp_rob(cmp_rob), .cmp_dest(cmp_dest),
    .cmp_data(cmp_data), .cmp_is_store(cmp_is_store), .busy(busy));

  int total = 0, bad = 0, cyc = 0;
  logic [7:0] mm [int];
  bit pend = 0, e_st, e_byte;
  int exp_cyc, hs_cyc, e_a, n_acc = 0, dut_ncmp = 0, cap_cyc;
  logic [31:0] e_pc, e_data, e_sd, m_last = 0, cap_data, cap_pc;
  logic [5:0]  e_rob, e_dest, cap_rob, cap_dest;
  logic        cap_st;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mbyte(input int a);
    return mm.exists(a) ? mm[a] : 8'h00;
  endfunction

  function automatic logic [31:0] mword(input int a);
    int b = a & ~3;
    return {mbyte(b + 3), mbyte(b + 2), mbyte(b + 1), mbyte(b)};
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rstn) begin
      pend = 0;
      m_last = 0;
    end else if (!pend && req_valid && req_pc != 0 && req_pc != m_last) begin
      bit f;
      f = req_fwd_valid && !req_is_store;
      m_last = req_pc; pend = 1; hs_cyc = cyc; n_acc++;
      exp_cyc = cyc + (f ? 0 : L);
      e_pc = req_pc; e_rob = req_rob; e_dest = req_dest; e_st = req_is_store;
      e_byte = req_byte; e_sd = req_store_data; e_a = int'(req_addr[9:0]);
      if (req_is_store)  e_data = 0;
      else if (f)        e_data = req_fwd_data;
      else if (req_byte) e_data = {{24{mbyte(e_a)[7]}}, mbyte(e_a)};
      else               e_data = mword(e_a);
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      pend = 0;
      check("rst_cmp_valid", cmp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_fields", {cmp_pc, cmp_data} == 0 && cmp_rob == 0 && cmp_dest == 0 && !cmp_is_store, 1);
    end else begin
      bit ev;
      ev = pend && (cyc == exp_cyc);
      check("cmp_valid", cmp_valid, ev);
      check("busy", busy, pend);
      check("req_ready", req_ready, !pend);
      if (cmp_valid) begin
        dut_ncmp++; cap_cyc = cyc; cap_data = cmp_data; cap_pc = cmp_pc;
        cap_rob = cmp_rob; cap_dest = cmp_dest; cap_st = cmp_is_store;
      end
      if (ev) begin
        check("cmp_pc", cmp_pc, e_pc);
        check("cmp_rob", cmp_rob, e_rob);
        check("cmp_dest", cmp_dest, e_dest);
        check("cmp_data", cmp_data, e_data);
        check("cmp_is_store", cmp_is_store, e_st);
        if (e_st) begin
          if (e_byte) mm[e_a] = e_sd[7:0];
          else for (int k = 0; k < 4; k++) mm[(e_a & ~3) + k] = e_sd[8*k +: 8];
        end
        pend = 0;
      end
    end
  end

  task automatic drive(input logic [31:0] pc, input logic [5:0] rob, input logic [5:0] dest,
                       input logic [31:0] addr, input bit st, input bit byt,
                       input logic [31:0] sd, input bit fv, input logic [31:0] fd);
    @(negedge clk); #1;
    req_valid = 1; req_pc = pc; req_rob = rob; req_dest = dest; req_addr = addr;
    req_is_store = st; req_byte = byt; req_store_data = sd; req_fwd_valid = fv; req_fwd_data = fd;
  endtask

  task automatic wait_accept(input int n0);
    int i;
    for (i = 0; i < 10 && n_acc == n0; i++) begin @(negedge clk); #2; end
    check("accept_timeout", n_acc != n0, 1);
  endtask

  task automatic send(input logic [31:0] pc, input logic [5:0] rob, input logic [5:0] dest,
                      input logic [31:0] addr, input bit st, input bit byt,
                      input logic [31:0] sd, input bit fv, input logic [31:0] fd);
    int n0 = n_acc, i;
    drive(pc, rob, dest, addr, st, byt, sd, fv, fd);
    wait_accept(n0);
    for (i = 0; i < 20 && pend; i++) begin @(negedge clk); #2; end
    check("complete_timeout", pend, 0);
    @(negedge clk); #1;
    req_valid = 0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1 rstn = 1;

    send(32'h4, 6'd1, 6'd2, 32'h10, 1, 0, 32'hDEADBEEF, 0, 0);
    check("st_latency", cap_cyc - hs_cyc, L);
    check("st_is_store", cap_st, 1);
    check("st_data", cap_data, 0);
    check("st_pc", cap_pc, 32'h4);

    send(32'h8, 6'd5, 6'd9, 32'h10, 0, 0, 0, 0, 0);
    check("ldw_data", cap_data, 32'hDEADBEEF);
    check("ldw_rob", cap_rob, 6'd5);
    check("ldw_dest", cap_dest, 6'd9);

    send(32'hC, 6'd6, 6'd0, 32'h12, 1, 1, 32'h12345680, 0, 0);
    send(32'h10, 6'd7, 6'd3, 32'h10, 0, 0, 0, 0, 0);
    check("ldw_after_sb", cap_data, 32'hDE80BEEF);
    send(32'h14, 6'd8, 6'd4, 32'h12, 0, 1, 0, 0, 0);
    check("ldb_sext", cap_data, 32'hFFFFFF80);

    send(32'h18, 6'd10, 6'd11, 32'h10, 0, 0, 0, 1, 32'h1234);
    check("fwd_data", cap_data, 32'h1234);
    check("fwd_latency", cap_cyc - hs_cyc, 0);

    n = dut_ncmp;
    drive(32'h18, 6'd10, 6'd11, 32'h10, 0, 0, 0, 1, 32'h1234);
    repeat (4) @(negedge clk);
    #1 req_pc = 0;
    repeat (3) @(negedge clk);
    #1 req_valid = 0;
    check("dup_suppressed", dut_ncmp, n);

    send(32'h1C, 6'd12, 6'd13, 32'h1010, 0, 0, 0, 0, 0);
    check("ld_wrap", cap_data, 32'hDE80BEEF);
    send(32'h1D, 6'd14, 6'd15, 32'h413, 0, 1, 0, 0, 0);
    check("ldb_lane3", cap_data, 32'hFFFFFFDE);
    send(32'h30, 6'd16, 6'd17, 32'h21, 1, 1, 32'hFFFFFF7F, 0, 0);
    send(32'h34, 6'd18, 6'd19, 32'h21, 0, 1, 0, 0, 0);
    check("ldb_pos", cap_data, 32'h0000007F);

    n = dut_ncmp;
    drive(32'h20, 6'd20, 6'd21, 32'h10, 1, 0, 32'h0, 0, 0);
    wait_accept(n_acc - (pend ? 1 : 0));
    #1 rstn = 0;
    repeat (2) @(negedge clk);
    #1 req_valid = 0; rstn = 1;
    repeat (2) @(negedge clk);
    check("abort_no_cmp", dut_ncmp, n);
    send(32'h24, 6'd22, 6'd23, 32'h10, 0, 0, 0, 0, 0);
    check("ld_after_abort", cap_data, 32'hDE80BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
